// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared width codes, FSM state type and error causes for the LSU.
// Rev    : 1.0
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2,
        ST_ERR  = 2'd3
    } lsu_state_t;

    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

    // Illegal width takes precedence over misalignment.
    function automatic logic [1:0] op_fault(input logic is_store,
                                            input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [1:0] cause;
        cause = EXC_NONE;
        case (f3)
            F3_B, F3_BU: cause = EXC_NONE;
            F3_H, F3_HU: cause = off[0] ? EXC_MISALIGN : EXC_NONE;
            F3_W:        cause = (off != 2'b00) ? EXC_MISALIGN : EXC_NONE;
            default:     cause = EXC_ILLEGAL;
        endcase
        if (is_store && f3[2]) begin
            cause = EXC_ILLEGAL;
        end
        return cause;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_align
// Brief  : Byte-enable / store-lane replication and load shift/extension.
// Rev    : 1.0
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] w_shift;
    logic        w_sext;

    assign w_shift = rdata >> {off, 3'b000};
    assign w_sext  = ~funct3[2];

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = rdata;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{w_sext & w_shift[7]}}, w_shift[7:0]};
            end
            2'b01: begin
                be        = 4'b0011 << off;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{w_sext & w_shift[15]}}, w_shift[15:0]};
            end
            2'b10: begin
                be        = 4'b1111;
            end
            default: begin
                be        = 4'b0000;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module : lsu_ctrl
// Brief  : Single-outstanding load/store sequencer with error detection.
// Rev    : 1.0
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        stall_o,
    output logic        exc_o,
    output logic [1:0]  exc_cause_o
);

    localparam logic [15:0] c_timeout = 16'(TIMEOUT_CYCLES);

    lsu_state_t  r_state, w_next;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic [15:0] r_cnt;
    logic [31:0] r_wb_data;
    logic [1:0]  r_exc_cause;

    logic        w_err_set;
    logic [1:0]  w_err_code;
    logic [1:0]  w_fault;
    logic        w_in_req;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_rep;
    logic [31:0] w_rdata_ext;

    lsu_align u_align (
        .funct3    (r_funct3),
        .off       (r_addr[1:0]),
        .wdata     (r_wdata),
        .rdata     (mem_rdata_i),
        .be        (w_be),
        .wdata_rep (w_wdata_rep),
        .rdata_ext (w_rdata_ext)
    );

    assign w_fault = op_fault(is_store_i, funct3_i, addr_i[1:0]);

    always_comb begin
        w_next     = r_state;
        w_err_set  = 1'b0;
        w_err_code = r_exc_cause;
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (w_fault != EXC_NONE) begin
                        w_next     = ST_ERR;
                        w_err_set  = 1'b1;
                        w_err_code = w_fault;
                    end else begin
                        w_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // An ack coinciding with the timeout threshold still completes.
                if (mem_ack_i) begin
                    w_next = r_is_store ? ST_IDLE : ST_WB;
                end else if (r_cnt == c_timeout) begin
                    w_next     = ST_ERR;
                    w_err_set  = 1'b1;
                    w_err_code = EXC_TIMEOUT;
                end
            end
            ST_WB:   w_next = ST_IDLE;
            ST_ERR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_rd        <= 5'd0;
            r_cnt       <= 16'd0;
            r_wb_data   <= 32'h0;
            r_exc_cause <= EXC_NONE;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && req_valid_i) begin
                r_is_store <= is_store_i;
                r_funct3   <= funct3_i;
                r_addr     <= addr_i;
                r_wdata    <= wdata_i;
                r_rd       <= rd_i;
            end
            // REQ is only entered from IDLE, so clearing here restarts the count.
            if (r_state == ST_IDLE) begin
                r_cnt <= 16'd0;
            end else if (r_state == ST_REQ && !mem_ack_i && r_cnt != c_timeout) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (r_state == ST_REQ && mem_ack_i && !r_is_store) begin
                r_wb_data <= w_rdata_ext;
            end
            if (w_err_set) begin
                r_exc_cause <= w_err_code;
            end
        end
    end

    assign w_in_req    = (r_state == ST_REQ);
    assign req_ready_o = (r_state == ST_IDLE);
    assign stall_o     = (r_state != ST_IDLE);
    assign mem_req_o   = w_in_req;
    assign mem_we_o    = w_in_req & r_is_store;
    assign mem_addr_o  = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign mem_be_o    = w_in_req ? w_be : 4'b0000;
    assign mem_wdata_o = w_in_req ? w_wdata_rep : 32'h0;
    assign wb_valid_o  = (r_state == ST_WB);
    assign wb_rd_o     = r_rd;
    assign wb_data_o   = r_wb_data;
    assign exc_o       = (r_state == ST_ERR);
    assign exc_cause_o = r_exc_cause;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_lsu_ctrl
// Brief  : Directed self-checking bench for lsu_ctrl against a timeline model.
// Rev    : 1.0
// ============================================================================
module tb_lsu_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [4:0]  rd = 5'd0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall, exc;
    logic [1:0]  exc_cause;

    lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .is_store_i(is_store), .funct3_i(funct3), .addr_i(addr),
        .wdata_i(wdata), .rd_i(rd),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .stall_o(stall), .exc_o(exc), .exc_cause_o(exc_cause)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int stall_hi = 0;
    logic chk_en = 1'b0;

    logic        e_ready, e_stall, e_req, e_exc, e_wbv;
    logic        e_we;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [3:0]  e_be;
    logic [4:0]  e_rd;
    logic [1:0]  m_cause = 2'b00;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an access of n bytes at byte offset off; lanes are memory bytes.
    function automatic int m_width(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [1:0] m_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
        int n = m_width(f3);
        if (n == 0 || (st && f3[2])) return 2'b11;
        if ((a % n) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n = m_width(f3);
        int off = int'(a[1:0]);
        logic [3:0] b = 4'b0;
        for (int i = 0; i < 4; i++) b[i] = (i >= off) && (i < off + n);
        return b;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int n = m_width(f3);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdat);
        int n = m_width(f3);
        int off = int'(a[1:0]);
        logic [31:0] r = 32'h0;
        for (int j = 0; j < n; j++) r[8*j +: 8] = rdat[8*(off+j) +: 8];
        if (n < 4 && !f3[2] && r[8*n-1])
            for (int j = n; j < 4; j++) r[8*j +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic set_exp(input logic rdy, input logic stl, input logic rq, input logic ex, input logic wv);
        e_ready = rdy; e_stall = stl; e_req = rq; e_exc = ex; e_wbv = wv;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (stall) stall_hi++;
            cmp("req_ready", 32'(req_ready), 32'(e_ready));
            cmp("stall", 32'(stall), 32'(e_stall));
            cmp("mem_req", 32'(mem_req), 32'(e_req));
            cmp("exc", 32'(exc), 32'(e_exc));
            cmp("wb_valid", 32'(wb_valid), 32'(e_wbv));
            cmp("exc_cause", 32'(exc_cause), 32'(m_cause));
            if (e_req) begin
                cmp("mem_we", 32'(mem_we), 32'(e_we));
                cmp("mem_addr", mem_addr, e_addr);
                cmp("mem_be", 32'(mem_be), 32'(e_be));
                cmp("mem_wdata", mem_wdata, e_wdata);
            end
            if (e_wbv) begin
                cmp("wb_rd", 32'(wb_rd), 32'(e_rd));
                cmp("wb_data", wb_data, e_data);
            end
        end
    end

    // wait_n: REQ cycles before ack; beyond T means the op times out.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] r, input int wait_n,
                          input logic [31:0] rdat);
        logic [1:0] flt;
        logic acked;
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; rd = r;
        mem_ack = 1'b0;
        set_exp(1, 0, 0, 0, 0);
        cyc();
        req_valid = 1'b0;
        flt = m_fault(st, f3, a);
        if (flt != 2'b00) begin
            m_cause = flt;
            set_exp(0, 1, 0, 1, 0);
            cyc();
        end else begin
            acked = 1'b0;
            e_we = st; e_addr = {a[31:2], 2'b00}; e_be = m_be(f3, a); e_wdata = m_wdata(f3, wd);
            for (int k = 0; k <= T; k++) begin
                mem_ack = (k == wait_n);
                mem_rdata = (k == wait_n) ? rdat : ~rdat;
                set_exp(0, 1, 1, 0, 0);
                cyc();
                if (k == wait_n) begin
                    acked = 1'b1;
                    break;
                end
            end
            mem_ack = 1'b0;
            if (!acked) begin
                m_cause = 2'b10;
                set_exp(0, 1, 0, 1, 0);
                cyc();
            end else if (!st) begin
                e_rd = r; e_data = m_load(f3, a, rdat);
                set_exp(0, 1, 0, 0, 1);
                cyc();
            end
        end
        set_exp(1, 0, 0, 0, 0);
    endtask

    int s0;

    initial begin
        set_exp(1, 0, 0, 0, 0);
        e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0; e_data = 0; e_rd = 0;
        cyc(); cyc();
        cmp("reset_ready", 32'(req_ready), 32'd1);
        cmp("reset_outs", {mem_req, mem_we, wb_valid, stall, exc, exc_cause, mem_be},
            32'd0);
        cmp("reset_data", mem_addr | mem_wdata | wb_data | 32'(wb_rd), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Pin the model against hand-computed values.
        cmp("pin_lb", m_load(3'b000, 32'h1003, 32'h80FF_1234), 32'hFFFF_FF80);
        cmp("pin_lhu", m_load(3'b101, 32'h1002, 32'h8001_0000), 32'h0000_8001);
        cmp("pin_lh", m_load(3'b001, 32'h1002, 32'h8001_0000), 32'hFFFF_8001);
        cmp("pin_sb_be", 32'(m_be(3'b000, 32'h2001)), 32'h2);
        cmp("pin_sb_wd", m_wdata(3'b000, 32'hAB), 32'hABAB_ABAB);
        cmp("pin_lw_fault", 32'(m_fault(1'b0, 3'b010, 32'h3002)), 32'h1);

        run_op(0, 3'b000, 32'h1003, 32'h0, 5'd5, 0, 32'h80FF_1234);
        run_op(0, 3'b101, 32'h1002, 32'h0, 5'd6, 1, 32'h8001_0000);
        run_op(0, 3'b001, 32'h1002, 32'h0, 5'd7, 0, 32'h8001_0000);
        s0 = stall_hi;
        run_op(1, 3'b000, 32'h2001, 32'h0000_00AB, 5'd0, 3, 32'h0);
        cmp("sb_stall_cycles", 32'(stall_hi - s0), 32'd4);
        run_op(1, 3'b001, 32'h2002, 32'h5555_1234, 5'd0, 0, 32'h0);
        run_op(1, 3'b010, 32'h2004, 32'hDEAD_BEEF, 5'd0, 2, 32'h0);
        run_op(0, 3'b100, 32'h1001, 32'h0, 5'd9, 0, 32'h1234_8056);
        run_op(0, 3'b010, 32'h1000, 32'h0, 5'd10, 0, 32'hCAFE_F00D);
        run_op(0, 3'b010, 32'h3002, 32'h0, 5'd11, 0, 32'h0);
        run_op(0, 3'b011, 32'h3000, 32'h0, 5'd11, 0, 32'h0);
        run_op(1, 3'b100, 32'h3000, 32'h0, 5'd0, 0, 32'h0);
        run_op(0, 3'b001, 32'h1001, 32'h0, 5'd12, 0, 32'h0);
        run_op(0, 3'b000, 32'h4000, 32'h0, 5'd13, 99, 32'h0);
        run_op(1, 3'b010, 32'h4000, 32'h1111_2222, 5'd0, T, 32'h0);
        run_op(0, 3'b001, 32'h4002, 32'h0, 5'd14, T, 32'hF00F_0000);

        // Ack while idle must be ignored.
        mem_ack = 1'b1;
        cyc(); cyc();
        mem_ack = 1'b0;

        // Reset while a load is waiting for its ack; the late ack is dropped.
        req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h5000; rd = 5'd15;
        set_exp(1, 0, 0, 0, 0);
        cyc();
        req_valid = 1'b0;
        e_we = 0; e_addr = 32'h5000; e_be = 4'hF; e_wdata = m_wdata(3'b010, 32'h0);
        set_exp(0, 1, 1, 0, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_cause = 2'b00;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        set_exp(1, 0, 0, 0, 0);
        cyc();
        mem_ack = 1'b0;
        cyc(); cyc();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
